// File: rtl/layer1_pkg.sv
// layer1_pkg: shared definitions for the layer-1 ReLU / max-pool stage.
//   - frame FSM state type
//   - default image geometry and pixel width
//   - L0 / L1 memory address widths for the default geometry
package layer1_pkg;

   // Frame FSM: IDLE until the first pixel arrives, RUN until the last one.
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } st_t;

   localparam int IMG_W_DEF  = 64;  // image width and height, power of 2
   localparam int DATA_W_DEF = 20;  // signed Q4.16 pixel

   // Address widths for the default 64x64 image.
   localparam int L0_AW_DEF = 2 * $clog2(IMG_W_DEF);        // {row, col}
   localparam int L1_AW_DEF = 2 * ($clog2(IMG_W_DEF) - 1);  // {row/2, col/2}

endpackage : layer1_pkg

// File: rtl/layer1_pool_row_buf.sv
// pool_row_buf: one-row line buffer for the 2x2 max-pool.
// Holds the horizontal pair-max of each window's top row until the
// bottom row of that window arrives.
//   clk   : rising-edge clock
//   we    : write strobe
//   waddr : write index (window column)
//   wdata : packed {ch1, ch0} partial max
//   raddr : read index (window column)
//   rdata : packed {ch1, ch0}, combinational read
// Writes happen on even rows and reads on odd rows, so a same-cycle
// read/write never touches the same entry and no bypass is needed.
// The contents are plain data and carry no reset.
module pool_row_buf #(
   parameter int DEPTH = 32,
   parameter int AW    = 5,
   parameter int W     = 40
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic [AW-1:0] raddr,
   output logic [W-1:0]  rdata
);

   logic [W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule : pool_row_buf

// File: rtl/layer1.sv
// layer1: ReLU + 2x2 stride-2 max-pool stage behind the layer-0 convolution.
// Consumes one two-channel pixel per accepted cycle in raster order, writes
// the ReLU'd image to L0 and the pooled half-size image to L1.
//   clk                    : rising-edge clock
//   reset                  : asynchronous, active-low; clears all state
//   i_valid                : pixel pair present this cycle
//   i_data_0 / i_data_1    : signed convolution results, kernel 0 / 1
//   o_l0_we/addr/data_0/1  : L0 write port, address {row, col}
//   o_l1_we/addr/data_0/1  : L1 write port, address {row/2, col/2}
//   o_busy                 : frame in progress
//   o_done                 : one-cycle pulse with the final L1 write
module layer1
   import layer1_pkg::*;
#(
   parameter int IMG_W  = IMG_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              i_valid,
   input  logic signed [DATA_W-1:0]          i_data_0,
   input  logic signed [DATA_W-1:0]          i_data_1,
   output logic                              o_l0_we,
   output logic [2*$clog2(IMG_W)-1:0]        o_l0_addr,
   output logic signed [DATA_W-1:0]          o_l0_data_0,
   output logic signed [DATA_W-1:0]          o_l0_data_1,
   output logic                              o_l1_we,
   output logic [2*($clog2(IMG_W)-1)-1:0]    o_l1_addr,
   output logic signed [DATA_W-1:0]          o_l1_data_0,
   output logic signed [DATA_W-1:0]          o_l1_data_1,
   output logic                              o_busy,
   output logic                              o_done
);

   localparam int CW = $clog2(IMG_W);  // counter width
   localparam int PW = 2 * DATA_W;     // packed {ch1, ch0} width

   // Negative inputs clamp to zero; everything else passes through.
   function automatic logic signed [DATA_W-1:0] relu(input logic signed [DATA_W-1:0] x);
      return x[DATA_W-1] ? '0 : x;
   endfunction

   // Operands are post-ReLU (non-negative), so an unsigned compare suffices.
   function automatic logic [DATA_W-1:0] max_u(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
      return (a > b) ? a : b;
   endfunction

   function automatic logic [PW-1:0] max_pair(input logic [PW-1:0] a,
                                              input logic [PW-1:0] b);
      return {max_u(a[PW-1:DATA_W], b[PW-1:DATA_W]),
              max_u(a[DATA_W-1:0],  b[DATA_W-1:0])};
   endfunction

   // ---- stage p0: counters, ReLU, pooling compares ----
   logic [CW-1:0]              col_p0;
   logic [CW-1:0]              row_p0;
   logic signed [DATA_W-1:0]   relu_0_p0;
   logic signed [DATA_W-1:0]   relu_1_p0;
   logic [PW-1:0]              relu_pair_p0;
   logic [PW-1:0]              pr_p0;
   logic [PW-1:0]              lb_rdata_p0;
   logic [PW-1:0]              pool_p0;
   logic                       lb_we_p0;
   logic                       last_p0;
   st_t                        st;

   assign relu_0_p0    = relu(i_data_0);
   assign relu_1_p0    = relu(i_data_1);
   assign relu_pair_p0 = {relu_1_p0, relu_0_p0};

   // Odd columns combine with the left neighbour held in pr; an odd-row even
   // column combines with the top-row pair max saved in the line buffer.
   assign pool_p0  = max_pair(col_p0[0] ? pr_p0 : lb_rdata_p0, relu_pair_p0);
   assign lb_we_p0 = i_valid & ~row_p0[0] & col_p0[0];
   assign last_p0  = (&row_p0) & (&col_p0);

   pool_row_buf #(
      .DEPTH (IMG_W / 2),
      .AW    (CW - 1),
      .W     (PW)
   ) u_lb (
      .clk   (clk),
      .we    (lb_we_p0),
      .waddr (col_p0[CW-1:1]),
      .wdata (pool_p0),
      .raddr (col_p0[CW-1:1]),
      .rdata (lb_rdata_p0)
   );

   // ---- stage p1: registered memory write ports ----
   logic                       l0_we_p1;
   logic [2*CW-1:0]            l0_addr_p1;
   logic signed [DATA_W-1:0]   l0_data_0_p1;
   logic signed [DATA_W-1:0]   l0_data_1_p1;
   logic                       l1_we_p1;
   logic [2*(CW-1)-1:0]        l1_addr_p1;
   logic signed [DATA_W-1:0]   l1_data_0_p1;
   logic signed [DATA_W-1:0]   l1_data_1_p1;
   logic                       busy_p1;
   logic                       done_p1;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         col_p0       <= '0;
         row_p0       <= '0;
         pr_p0        <= '0;
         l0_we_p1     <= 1'b0;
         l0_addr_p1   <= '0;
         l0_data_0_p1 <= '0;
         l0_data_1_p1 <= '0;
         l1_we_p1     <= 1'b0;
         l1_addr_p1   <= '0;
         l1_data_0_p1 <= '0;
         l1_data_1_p1 <= '0;
      end else begin
         l0_we_p1 <= i_valid;
         l1_we_p1 <= i_valid & row_p0[0] & col_p0[0];
         if (i_valid) begin
            l0_addr_p1   <= {row_p0, col_p0};
            l0_data_0_p1 <= relu_0_p0;
            l0_data_1_p1 <= relu_1_p0;
            // Even column opens a horizontal pair: fresh pixel on the top
            // row, top-row max folded in on the bottom row.
            if (!col_p0[0]) begin
               pr_p0 <= row_p0[0] ? pool_p0 : relu_pair_p0;
            end
            if (row_p0[0] && col_p0[0]) begin
               l1_addr_p1   <= {row_p0[CW-1:1], col_p0[CW-1:1]};
               l1_data_0_p1 <= pool_p0[DATA_W-1:0];
               l1_data_1_p1 <= pool_p0[PW-1:DATA_W];
            end
            col_p0 <= col_p0 + 1'b1;
            if (&col_p0) begin
               row_p0 <= row_p0 + 1'b1;
            end
         end
      end
   end

   // Frame FSM; busy and done are registered alongside the p1 write ports.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         st      <= ST_IDLE;
         busy_p1 <= 1'b0;
         done_p1 <= 1'b0;
      end else begin
         done_p1 <= 1'b0;
         case (st)
            ST_IDLE: begin
               if (i_valid) begin
                  st      <= ST_RUN;
                  busy_p1 <= 1'b1;
               end
            end
            ST_RUN: begin
               if (i_valid && last_p0) begin
                  st      <= ST_IDLE;
                  busy_p1 <= 1'b0;
                  done_p1 <= 1'b1;
               end
            end
            default: begin
               st      <= ST_IDLE;
               busy_p1 <= 1'b0;
            end
         endcase
      end
   end

   assign o_l0_we     = l0_we_p1;
   assign o_l0_addr   = l0_addr_p1;
   assign o_l0_data_0 = l0_data_0_p1;
   assign o_l0_data_1 = l0_data_1_p1;
   assign o_l1_we     = l1_we_p1;
   assign o_l1_addr   = l1_addr_p1;
   assign o_l1_data_0 = l1_data_0_p1;
   assign o_l1_data_1 = l1_data_1_p1;
   assign o_busy      = busy_p1;
   assign o_done      = done_p1;

endmodule : layer1

// File: tb/tb_layer1.sv
// tb_layer1: directed bench for layer1 (64x64 image, 20-bit pixels).
// Hand-checked ReLU / pooling vectors, then full frames against a small
// reference model with idle gaps, a mid-frame reset and back-to-back frames.
module tb_layer1;

   logic        clk = 1'b0;
   logic        reset;
   logic        i_valid;
   logic [19:0] i_data_0;
   logic [19:0] i_data_1;
   logic        o_l0_we;
   logic [11:0] o_l0_addr;
   logic [19:0] o_l0_data_0;
   logic [19:0] o_l0_data_1;
   logic        o_l1_we;
   logic [9:0]  o_l1_addr;
   logic [19:0] o_l1_data_0;
   logic [19:0] o_l1_data_1;
   logic        o_busy;
   logic        o_done;

   int vectors     = 0;
   int miscompares = 0;
   int l0_cnt      = 0;
   int l1_cnt      = 0;
   int done_cnt    = 0;

   // Reference model state
   logic [5:0]  m_row, m_col;
   logic [19:0] m_pr0, m_pr1;
   logic [19:0] m_lb0 [32];
   logic [19:0] m_lb1 [32];
   logic        m_busy;
   logic [11:0] m_l0_addr;

   layer1 #(.IMG_W(64), .DATA_W(20)) dut (
      .clk         (clk),
      .reset       (reset),
      .i_valid     (i_valid),
      .i_data_0    (i_data_0),
      .i_data_1    (i_data_1),
      .o_l0_we     (o_l0_we),
      .o_l0_addr   (o_l0_addr),
      .o_l0_data_0 (o_l0_data_0),
      .o_l0_data_1 (o_l0_data_1),
      .o_l1_we     (o_l1_we),
      .o_l1_addr   (o_l1_addr),
      .o_l1_data_0 (o_l1_data_0),
      .o_l1_data_1 (o_l1_data_1),
      .o_busy      (o_busy),
      .o_done      (o_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [19:0] m_relu(input logic [19:0] x);
      return x[19] ? 20'h0 : x;
   endfunction

   function automatic logic [19:0] m_max(input logic [19:0] a, input logic [19:0] b);
      return (a > b) ? a : b;
   endfunction

   task automatic model_reset();
      m_row     = '0;
      m_col     = '0;
      m_pr0     = '0;
      m_pr1     = '0;
      m_busy    = 1'b0;
      m_l0_addr = '0;
   endtask

   // One accepted pixel; outputs sampled 1 ns after the capturing edge.
   task automatic pix(input logic [19:0] d0, input logic [19:0] d1);
      logic [19:0] r0, r1, e0, e1;
      logic        last, odd_odd;
      r0 = m_relu(d0);
      r1 = m_relu(d1);
      e0 = '0;
      e1 = '0;
      last    = (m_row == 6'd63) && (m_col == 6'd63);
      odd_odd = m_row[0] && m_col[0];
      case ({m_row[0], m_col[0]})
         2'b00: begin m_pr0 = r0; m_pr1 = r1; end
         2'b01: begin
            m_lb0[m_col[5:1]] = m_max(m_pr0, r0);
            m_lb1[m_col[5:1]] = m_max(m_pr1, r1);
         end
         2'b10: begin
            m_pr0 = m_max(m_lb0[m_col[5:1]], r0);
            m_pr1 = m_max(m_lb1[m_col[5:1]], r1);
         end
         default: begin e0 = m_max(m_pr0, r0); e1 = m_max(m_pr1, r1); end
      endcase
      i_valid  = 1'b1;
      i_data_0 = d0;
      i_data_1 = d1;
      @(posedge clk);
      #1;
      i_valid = 1'b0;
      m_l0_addr = {m_row, m_col};
      m_busy    = !last;
      chk("l0_we",   o_l0_we, 1'b1);
      chk("l0_addr", o_l0_addr, m_l0_addr);
      chk("l0_d0",   o_l0_data_0, r0);
      chk("l0_d1",   o_l0_data_1, r1);
      chk("l1_we",   o_l1_we, odd_odd);
      if (odd_odd) begin
         chk("l1_addr", o_l1_addr, {m_row[5:1], m_col[5:1]});
         chk("l1_d0",   o_l1_data_0, e0);
         chk("l1_d1",   o_l1_data_1, e1);
      end
      chk("done", o_done, last);
      chk("busy", o_busy, m_busy);
      if (o_l0_we) l0_cnt++;
      if (o_l1_we) l1_cnt++;
      if (o_done)  done_cnt++;
      m_col = m_col + 6'd1;
      if (m_col == 6'd0) m_row = m_row + 6'd1;
   endtask

   // Idle cycle: no strobes, state and output registers hold.
   task automatic gap();
      i_valid  = 1'b0;
      i_data_0 = 20'($urandom);
      i_data_1 = 20'($urandom);
      @(posedge clk);
      #1;
      chk("gap_l0_we",   o_l0_we, 1'b0);
      chk("gap_l1_we",   o_l1_we, 1'b0);
      chk("gap_done",    o_done, 1'b0);
      chk("gap_busy",    o_busy, m_busy);
      chk("gap_l0_addr", o_l0_addr, m_l0_addr);
   endtask

   task automatic frame(input int n_pix, input bit gaps);
      for (int k = 0; k < n_pix; k++) begin
         if (gaps && ($urandom_range(3) == 0)) gap();
         pix(20'($urandom), 20'($urandom));
      end
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_l0_we"}, o_l0_we, 1'b0);
      chk({tag, "_l0_addr"}, o_l0_addr, 12'h0);
      chk({tag, "_l0_d"}, {o_l0_data_1, o_l0_data_0}, 40'h0);
      chk({tag, "_l1_we"}, o_l1_we, 1'b0);
      chk({tag, "_l1_addr"}, o_l1_addr, 10'h0);
      chk({tag, "_l1_d"}, {o_l1_data_1, o_l1_data_0}, 40'h0);
      chk({tag, "_busy"}, o_busy, 1'b0);
      chk({tag, "_done"}, o_done, 1'b0);
   endtask

   // Reset asserted between edges, held across two edges with i_valid high.
   task automatic reset_pulse();
      #2;
      reset = 1'b0;
      #1;
      check_all_zero("rst_async");
      i_valid  = 1'b1;
      i_data_0 = 20'h12345;
      i_data_1 = 20'h23456;
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("rst_hold");
      i_valid = 1'b0;
      reset   = 1'b1;
      model_reset();
   endtask

   initial begin
      reset    = 1'b0;
      i_valid  = 1'b0;
      i_data_0 = '0;
      i_data_1 = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("por");
      reset = 1'b1;
      gap();

      // ReLU on both polarity extremes at (0,0)
      pix(20'h80000, 20'h7FFFF);
      chk("relu_addr", o_l0_addr, 12'h000);
      chk("relu_d0",   o_l0_data_0, 20'h00000);
      chk("relu_d1",   o_l0_data_1, 20'h7FFFF);
      chk("relu_busy_rise", o_busy, 1'b1);
      reset_pulse();

      // Window 0: 5,9 / 3,7 -> 9.  Window 1: all negative -> 0.
      pix(20'd5, 20'd5);
      pix(20'd9, 20'd9);
      pix(20'hFFFFB, 20'h80000);
      chk("neg_l0_d0", o_l0_data_0, 20'h0);
      pix(20'hFFFF0, 20'hFFFFF);
      chk("neg_l0_d1", o_l0_data_1, 20'h0);
      for (int c = 4; c < 64; c++) pix(20'h0, 20'h0);
      pix(20'd3, 20'd3);
      chk("win0_no_l1_early", o_l1_we, 1'b0);
      pix(20'd7, 20'd7);
      chk("win0_l1_we",   o_l1_we, 1'b1);
      chk("win0_l1_addr", o_l1_addr, 10'h000);
      chk("win0_l1_d0",   o_l1_data_0, 20'd9);
      chk("win0_l1_d1",   o_l1_data_1, 20'd9);
      chk("win0_l0_addr", o_l0_addr, 12'h041);
      pix(20'h80001, 20'hFFFFF);
      pix(20'hC0000, 20'h80000);
      chk("win1_l1_addr", o_l1_addr, 10'h001);
      chk("win1_l1_d",    {o_l1_data_1, o_l1_data_0}, 40'h0);
      gap();
      chk("hold_l1_addr", o_l1_addr, 10'h001);
      reset_pulse();

      // Full frame with random gaps
      l0_cnt = 0; l1_cnt = 0; done_cnt = 0;
      frame(4096, 1'b1);
      chk("ff_l0_cnt", l0_cnt, 4096);
      chk("ff_l1_cnt", l1_cnt, 1024);
      chk("ff_done_cnt", done_cnt, 1);
      chk("ff_last_l1_addr", o_l1_addr, 10'h3FF);
      gap();

      // Reset after pixel 100, then a complete frame from (0,0)
      frame(101, 1'b1);
      reset_pulse();
      l0_cnt = 0; l1_cnt = 0; done_cnt = 0;
      frame(4096, 1'b1);
      chk("rf_l0_cnt", l0_cnt, 4096);
      chk("rf_l1_cnt", l1_cnt, 1024);
      chk("rf_done_cnt", done_cnt, 1);

      // Back-to-back frames with no idle cycle between them
      l0_cnt = 0; l1_cnt = 0; done_cnt = 0;
      frame(4096, 1'b0);
      pix(20'd1, 20'd2);
      chk("b2b_restart_addr", o_l0_addr, 12'h000);
      chk("b2b_busy_back", o_busy, 1'b1);
      frame(4095, 1'b0);
      chk("b2b_l0_cnt", l0_cnt, 8192);
      chk("b2b_l1_cnt", l1_cnt, 2048);
      chk("b2b_done_cnt", done_cnt, 2);
      gap();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_layer1
